// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-stage bundle: redirect inputs from decode, stall from hazard unit, imem request handshake.
// master = PC controller side, slave = surrounding pipeline / memory side.
interface fetch_pc_ctrl_if;
  logic        stall;
  logic        redirect_valid;
  logic [2:0]  redirect_op;
  logic        judge_b;
  logic [31:0] branch_pc;
  logic [31:0] offset_ext;
  logic [25:0] instr_index;
  logic [31:0] pc_rs;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] pc_out;
  logic        fetch_valid;
  logic        pending;
  logic        op_err;
  logic        addr_err;

  modport master (
    input  stall, redirect_valid, redirect_op, judge_b, branch_pc, offset_ext,
           instr_index, pc_rs, imem_ready,
    output imem_req, imem_addr, pc_out, fetch_valid, pending, op_err, addr_err
  );

  modport slave (
    output stall, redirect_valid, redirect_op, judge_b, branch_pc, offset_ext,
           instr_index, pc_rs, imem_ready,
    input  imem_req, imem_addr, pc_out, fetch_valid, pending, op_err, addr_err
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// PC sequencer with delay-slot redirects; next PC lands the cycle after fire, request held until imem_ready.
// Optional ALIGN_CHK_EN: word-aligns jr targets and flags misaligned ones on addr_err.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input logic           clk,
  input logic           rst_n,
  fetch_pc_ctrl_if.master bus
);

  typedef enum logic [1:0] {ST_BOOT, ST_REQ, ST_HOLD} state_t;

  localparam logic [2:0] OP_BEQ = 3'b001;
  localparam logic [2:0] OP_JAL = 3'b010;
  localparam logic [2:0] OP_JR  = 3'b011;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_target;
  logic        r_imem_req;
  logic        r_fetch_valid;
  logic        r_pending;
  logic        r_op_err;

  logic        w_fire;
  logic        w_bad_op;
  logic        w_taken;
  logic        w_accept;
  logic        w_nest_err;
  logic [31:0] w_target;
  logic [31:0] w_pc_next;
  logic        w_unused;

  assign w_fire     = r_imem_req & bus.imem_ready;
  assign w_bad_op   = bus.redirect_valid & bus.redirect_op[2];
  assign w_taken    = bus.redirect_valid & ~bus.redirect_op[2] &
                      ((bus.redirect_op == OP_JAL) | (bus.redirect_op == OP_JR) |
                       ((bus.redirect_op == OP_BEQ) & bus.judge_b));
  assign w_accept   = w_taken & (r_state != ST_BOOT) & ~r_pending;
  // A control instruction sitting in a delay slot is not supported.
  assign w_nest_err = w_taken & r_pending;
  assign w_unused   = ^bus.offset_ext[31:30];

  always_comb begin
    w_target = bus.pc_rs;
    case (bus.redirect_op)
      OP_BEQ:  w_target = bus.branch_pc + 32'd4 + {bus.offset_ext[29:0], 2'b00};
      OP_JAL:  w_target = {bus.branch_pc[31:28], bus.instr_index, 2'b00};
`ifdef ALIGN_CHK_EN
      OP_JR:   w_target = {bus.pc_rs[31:2], 2'b00};
`else
      OP_JR:   w_target = bus.pc_rs;
`endif
      default: w_target = bus.pc_rs;
    endcase
  end

  // A held target outranks everything; otherwise a same-cycle redirect makes this fetch the delay slot.
  assign w_pc_next = r_pending ? r_target : (w_accept ? w_target : r_pc + 32'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_PC;
      r_target      <= 32'd0;
      r_imem_req    <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_pending     <= 1'b0;
      r_op_err      <= 1'b0;
    end else begin
      r_fetch_valid <= w_fire;
      if (w_bad_op | w_nest_err) r_op_err <= 1'b1;

      if (w_fire) begin
        r_pc      <= w_pc_next;
        r_pending <= 1'b0;
      end else if (w_accept) begin
        r_pending <= 1'b1;
        r_target  <= w_target;
      end

      case (r_state)
        ST_BOOT: begin
          r_state    <= bus.stall ? ST_HOLD : ST_REQ;
          r_imem_req <= ~bus.stall;
        end
        ST_REQ: begin
          if (w_fire && bus.stall) begin
            r_state    <= ST_HOLD;
            r_imem_req <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!bus.stall) begin
            r_state    <= ST_REQ;
            r_imem_req <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_HOLD;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALIGN_CHK_EN
  logic r_addr_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_err <= 1'b0;
    end else if (w_accept && (bus.redirect_op == OP_JR) && (bus.pc_rs[1:0] != 2'b00)) begin
      r_addr_err <= 1'b1;
    end
  end
  assign bus.addr_err = r_addr_err;
`else
  assign bus.addr_err = 1'b0;
`endif

  assign bus.imem_req    = r_imem_req;
  assign bus.imem_addr   = r_pc;
  assign bus.pc_out      = r_pc;
  assign bus.fetch_valid = r_fetch_valid;
  assign bus.pending     = r_pending;
  assign bus.op_err      = r_op_err;

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- PC sequencer for the fetch stage. Owns the PC register and drives the instruction-memory request handshake.
- Accepts stall from the hazard unit and branch/jump redirects from the decode stage. Applies MIPS delay-slot semantics: the redirect takes effect after the delay-slot fetch.
- Uses the shared next-PC op encoding: 3'b000 order, 3'b001 beq, 3'b010 jal, 3'b011 jr.

Parameters:
RESET_PC, 32'h0000_3000, PC value after reset.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
stall  input  1  hazard-unit freeze request
redirect_valid  input  1  decode stage presents a control instruction this cycle
redirect_op  input  3  next-PC op of that instruction
judge_b  input  1  branch condition result, valid with redirect_valid
branch_pc  input  32  PC of the redirecting instruction
offset_ext  input  32  sign-extended 16-bit branch offset
instr_index  input  26  jal index field
pc_rs  input  32  jr register value
imem_req  output  1  fetch request
imem_addr  output  32  fetch address, equals pc_out
imem_ready  input  1  memory accepts the request this cycle
pc_out  output  32  current fetch PC
fetch_valid  output  1  registered pulse, one cycle after each accepted fetch
pending  output  1  a redirect target is held awaiting the delay-slot fetch
op_err  output  1  sticky error flag

Behaviour:
- Reset values (async, rst_n=0): state=BOOT, pc_out=RESET_PC, imem_req=0, fetch_valid=0, pending=0, op_err=0, target register=0.
- fire = imem_req & imem_ready.
- States:
  - BOOT: exactly one cycle after reset release. Next state is REQ if stall=0, HOLD if stall=1.
  - REQ: imem_req=1.
    - On fire with stall=0: stay in REQ, pc updates.
    - On fire with stall=1: go to HOLD, pc updates.
    - No fire: stay in REQ; pc and imem_req held.
  - HOLD: imem_req=0, pc frozen. Go to REQ when stall=0.
- Handshake rule: once imem_req=1, it and imem_addr stay stable until fire. A stall arriving mid-request takes effect after fire.
- Target computation, from branch_pc:
  - beq: branch_pc + 4 + {offset_ext[29:0], 2'b00}, modulo 2^32.
  - jal: {branch_pc[31:28], instr_index, 2'b00}.
  - jr: pc_rs.
- Redirect counts as taken for jal, jr, or beq with judge_b=1. It is a no-op for order, or beq with judge_b=0.
- Taken redirect is accepted in any state except BOOT. It sets pending=1 and latches the target.
- On fire:
  - next pc = target if pending, else pc_out + 4 (wraps at 2^32). pending then clears.
  - Redirect and fire in the same cycle: the new target is used directly, pending stays 0. The current fetch is treated as the delay slot.
- Taken redirect while pending=1 (control instruction in a delay slot): ignored, op_err set.
- redirect_op[2]=1: ignored, op_err set.
- op_err clears only on reset.
- fetch_valid = registered fire; it may fall in a HOLD cycle.
- Reset asserted mid-request: imem_req drops immediately (async) and the transaction is abandoned.

Optional Feature:
ALIGN_CHK_EN
- Defined:
  - adds output addr_err (1 bit, sticky, reset 0).
  - jr target with pc_rs[1:0]!=0 sets addr_err and latches the target with bits [1:0] forced to 0.
- Undefined: the jr target is used unmodified and addr_err is tied to 0.

Test Plan:
- Reset release, imem_ready=1, no stall: pc_out is 0x3000 during BOOT, then 0x3000, 0x3004, 0x3008 on consecutive cycles; fetch_valid high from the cycle after the first fire.
- Wait states: imem_ready low for 3 cycles at pc=0x3004, stall pulsed mid-wait -> imem_req and addr 0x3004 held; fire, then HOLD until stall=0; next fetch is 0x3008.
- beq taken, same-cycle fire: branch_pc=0x3008, offset_ext=0xFFFF_FFFE, judge_b=1, fire with pc_out=0x300C -> next pc=0x3004, pending=0. Same stimulus with judge_b=0 -> next pc=0x3010.
- Redirect during stall: jal with branch_pc=0x3010, instr_index=0x0000C40 while in HOLD -> pending=1; after release, 0x3014 (delay slot) is fetched, then 0x0000_3100; pending clears on the 0x3014 fire.
- Error paths:
  - jr taken while pending=1 -> ignored, op_err=1, original target kept.
  - redirect_op=3'b101 -> op_err=1.
  - op_err stays 1 until rst_n=0.
- Alignment (run with ALIGN_CHK_EN defined and undefined): jr with pc_rs=0x0000_3022 -> with the macro, target 0x3020 and addr_err=1; without it, target 0x3022 and addr_err=0.
